param_stack: RTL
================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, 32, number of entries (power of two, >=2).
REQ-003 Parameter CNT_W, $clog2(DEPTH)+1, width of the occupancy count.
REQ-004 Port clk input 1 -- single clock; all state updates on its rising edge.
REQ-005 Port rst input 1 -- reset, synchronous, active-high.
REQ-006 Port din input WIDTH -- data to push.
REQ-007 Port push input 1 -- push request.
REQ-008 Port pop input 1 -- pop request; returns top entry.
REQ-009 Port tos input 1 -- peek request; returns top entry without removal.
REQ-010 Port clear input 1 -- empties the stack in one cycle.
REQ-011 Port dout output WIDTH -- registered read data.
REQ-012 Port dout_valid output 1 -- one-cycle pulse: dout updated this cycle.
REQ-013 Port count output CNT_W -- current occupancy, 0..DEPTH.
REQ-014 Port full output 1 -- count == DEPTH.
REQ-015 Port empty output 1 -- count == 0.
REQ-016 Port overflow output 1 -- sticky: push rejected while full.
REQ-017 Port underflow output 1 -- sticky: pop/tos rejected while empty.

Function
REQ-018 Top entry SHALL be mem[count-1]; push SHALL write mem[count] and increment count.
REQ-019 Accepted pop SHALL load dout <= mem[count-1], decrement count, pulse dout_valid next cycle-edge.
REQ-020 Accepted tos SHALL load dout <= mem[count-1], count unchanged, pulse dout_valid.
REQ-021 Read latency: dout/dout_valid valid one clock after the request edge; dout holds its value until the next accepted read.
REQ-022 push+pop same cycle, count>0: replace top -- dout <= old top, mem[count-1] <= din, count unchanged, dout_valid pulses.
REQ-023 push+pop same cycle, count==0: push only accepted; underflow set; dout_valid stays low.
REQ-024 tos with pop: treated as pop; tos with push (no pop): dout <= pre-push top, then push applied.
REQ-025 Push while full (without pop): rejected, memory and count unchanged, overflow set.
REQ-026 Pop or tos while empty: rejected, dout unchanged, dout_valid low, underflow set.
REQ-027 clear SHALL set count to 0 and clear overflow/underflow; clear has priority over all other requests in that cycle; memory contents are don't-care.
REQ-028 full/empty SHALL be combinational decodes of registered count; no wrap-around of count ever permitted.
REQ-029 Sticky flags SHALL remain set until clear or rst.

Reset
REQ-030 On rst at a clock edge: count=0, dout=0, dout_valid=0, overflow=0, underflow=0; memory NOT required to be zeroed.
REQ-031 rst SHALL override every request in the same cycle, including mid-sequence push/pop traffic.
REQ-032 First cycle after rst deasserts SHALL accept requests normally.

Structure
REQ-033 Package stack_pkg SHALL hold the op-priority enum (OP_NONE, OP_PUSH, OP_POP, OP_TOS, OP_REPLACE, OP_CLEAR) and default WIDTH/DEPTH constants.
REQ-034 Storage SHALL be a sub-module stack_ram (1 write port, 1 sync-free combinational read port, DEPTH x WIDTH); control, count and flags reside in param_stack.
REQ-035 Op decode SHALL be a single priority function producing one stack_pkg op per cycle.

Verification
REQ-036 rst, push 0x11,0x22,0x33, pop x3 -> dout 0x33,0x22,0x11 each one cycle after pop, dout_valid pulses x3, empty=1.
REQ-037 DEPTH=4: push 5 words 0xA0..0xA4 -> count=4, full=1, overflow=1, then pops return 0xA3..0xA0.
REQ-038 Empty stack, pop then tos -> dout unchanged (0), dout_valid never high, underflow=1; clear -> underflow=0.
REQ-039 Stack holds 0x05, push 0x09 with pop -> dout=0x05, count=1, next tos returns 0x09.
REQ-040 push 0x7E, tos -> dout=0x7E, count=1; assert rst during a push -> count=0, dout=0, flags 0 next cycle.
REQ-041 WIDTH=16, DEPTH=8 instance: fill, drain, randomised push/pop against reference queue model, zero mismatches.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the parameterised LIFO stack: default sizes,
// the per-cycle operation enum and the single priority decode function.
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 32;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_TOS,
        OP_REPLACE,
        OP_CLEAR
    } op_t;

    // Reduce the raw request lines to exactly one operation per cycle.
    // clear beats everything; push+pop replaces the top unless the stack
    // is empty, in which case only the push survives; pop beats tos.
    function automatic op_t decode_op(input logic push,
                                      input logic pop,
                                      input logic tos,
                                      input logic clear,
                                      input logic empty);
        op_t op;
        op = OP_NONE;
        if (clear)
            op = OP_CLEAR;
        else if (push && pop)
            op = empty ? OP_PUSH : OP_REPLACE;
        else if (pop)
            op = OP_POP;
        else if (push)
            op = OP_PUSH;
        else if (tos)
            op = OP_TOS;
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Storage array for the stack: one synchronous write port and one
// combinational read port. Contents are never reset.
module stack_ram
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// LIFO stack controller: decodes requests into one operation per cycle,
// tracks occupancy, registers read data and keeps sticky error flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    op_t              op;
    logic [AW-1:0]    cnt_lo;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rdata;
    logic             we;
    logic             rd_en;
    logic             ovf_set;
    logic             unf_set;
    logic [CNT_W-1:0] count_nxt;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign cnt_lo = count[AW-1:0];
    assign top_addr = cnt_lo - AW'(1);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (top_addr),
        .rdata (rdata)
    );

    // Decode the cycle's operation and derive write, read, count and flag updates.
    always_comb begin
        op        = decode_op(push, pop, tos, clear, empty);
        we        = 1'b0;
        waddr     = cnt_lo;
        rd_en     = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        count_nxt = count;
        case (op)
            OP_CLEAR: begin
                count_nxt = '0;
            end
            OP_REPLACE: begin
                we    = 1'b1;
                waddr = top_addr;
                rd_en = 1'b1;
            end
            OP_PUSH: begin
                rd_en   = tos && !pop && !empty;
                unf_set = pop;
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    we        = 1'b1;
                    count_nxt = count + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    rd_en     = 1'b1;
                    count_nxt = count - CNT_W'(1);
                end
            end
            OP_TOS: begin
                if (empty)
                    unf_set = 1'b1;
                else
                    rd_en = 1'b1;
            end
            default: begin
                count_nxt = count;
            end
        endcase
    end

    // Register occupancy, read data, the valid pulse and the sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_nxt;
            dout_valid <= rd_en;
            if (rd_en)
                dout <= rdata;
            if (op == OP_CLEAR) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                overflow  <= overflow | ovf_set;
                underflow <= underflow | unf_set;
            end
        end
    end

endmodule
